// File: rtl/inst_fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : inst_fetch_unit_pkg                                          |
// | Description : Shared types and constants for the instruction fetch unit.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FLUSH = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INST_BYTES       = 32'd4;

  // One buffered instruction together with the address it was fetched from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_unit_fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_fifo                                                   |
// | Description : Synchronous FIFO of {pc, inst} entries with single-cycle     |
// |               flush. Head is read combinationally; writes are registered. |
// |               Simultaneous push and pop are legal, even when full.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage write; the array itself needs no reset because count gates reads
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; flush empties the buffer in one cycle
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : inst_fetch_unit                                              |
// | Description : Pipeline front end. Generates the PC, issues credit-limited  |
// |               word reads to instruction memory, buffers responses in      |
// |               order and hands them to the decoder. Redirects flush the    |
// |               buffer and drop responses that are still in flight.         |
// |               Optional macro FETCH_PERF_CNT_EN adds perf_fetched and       |
// |               perf_stall counters.                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic [31:0]      fetch_pc;
  logic [31:0]      rsp_pc;
  logic [31:0]      redirect_aligned;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_next;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] drop_cnt_next;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;
  logic             redirect_take;
  logic             credit_ok;
  logic             req_fire;
  logic             rsp_seen;
  logic             rsp_push;
  logic             inst_pop;

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign redirect_take    = redirect_valid && (state != FETCH_BOOT);

  // Credit uses registered occupancy only, so a same-cycle pop never frees a slot
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < SUM_W'(FIFO_DEPTH);

  assign imem_req_valid = (state == FETCH_RUN) && credit_ok && !redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_seen         = imem_rsp_valid && (outstanding != '0);
  assign outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_seen);

  // The full guard never blocks under the credit rule; it only protects the
  // buffer from a memory that returns more words than were requested.
  assign rsp_push   = imem_rsp_valid && (state == FETCH_RUN) && !redirect_take &&
                      (!fifo_full || inst_pop);
  assign push_entry = '{pc: rsp_pc, inst: imem_rsp_data};

  assign inst_valid = !fifo_empty && !redirect_valid;
  assign inst_pop   = inst_valid && inst_ready;
  assign inst       = fifo_empty ? INST_NOP : fifo_head.inst;
  assign inst_pc    = fifo_empty ? rsp_pc   : fifo_head.pc;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_take),
    .push      (rsp_push),
    .push_data (push_entry),
    .pop       (inst_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Next-state logic: a redirect with words still in flight parks in FLUSH
  always_comb begin
    state_next    = state;
    drop_cnt_next = drop_cnt;
    case (state)
      FETCH_BOOT: begin
        state_next = FETCH_RUN;
      end
      FETCH_RUN: begin
        if (redirect_take) begin
          drop_cnt_next = outstanding_next;
          state_next    = (outstanding_next != '0) ? FETCH_FLUSH : FETCH_RUN;
        end
      end
      FETCH_FLUSH: begin
        drop_cnt_next = drop_cnt - CNT_W'(rsp_seen);
        if (drop_cnt_next == '0) begin
          state_next = FETCH_RUN;
        end
      end
      default: begin
        state_next = FETCH_BOOT;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // PC and request-credit registers
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      drop_cnt    <= drop_cnt_next;
      if (redirect_take) begin
        fetch_pc <= redirect_aligned;
        rsp_pc   <= redirect_aligned;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + INST_BYTES;
        end
        if (rsp_push) begin
          rsp_pc <= rsp_pc + INST_BYTES;
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Delivered-instruction and RUN-stall event counters, free-running with wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (inst_pop) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if ((state == FETCH_RUN) && !inst_valid) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
